// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: single-request memory bus controller between the datapath and
// the external memory port. Runs the readM/writeM strobe handshake on a shared
// bidirectional data bus and reports completion with a one-cycle done pulse.
// Optional feature macro: BUS_TIMEOUT_EN (wait-state timeout with err flag).
module mem_bus_ctrl #(
  parameter int unsigned WORD_SIZE      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 fetch_req,
  input  logic                 rd_req,
  input  logic                 wr_req,
  input  logic [WORD_SIZE-1:0] req_addr,
  input  logic [WORD_SIZE-1:0] wr_data,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [WORD_SIZE-1:0] instruction,
  output logic [WORD_SIZE-1:0] rd_data,
  output logic                 readM,
  output logic                 writeM,
  output logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data,
  input  logic                 inputReady,
  input  logic                 ackOutput
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    READ  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Timeout limit only fits an 8-bit wait counter.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("mem_bus_ctrl: TIMEOUT_CYCLES must be in 1..255");
  end

  state_t                 state_q, state_d;
  logic [WORD_SIZE-1:0]   address_q, address_d;
  logic [WORD_SIZE-1:0]   wr_reg_q, wr_reg_d;
  logic [WORD_SIZE-1:0]   instr_q, instr_d;
  logic [WORD_SIZE-1:0]   rd_data_q, rd_data_d;
  logic                   read_m_q, read_m_d;
  logic                   write_m_q, write_m_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
`endif

  // State and registered outputs; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      address_q  <= '0;
      wr_reg_q   <= '0;
      instr_q    <= '0;
      rd_data_q  <= '0;
      read_m_q   <= 1'b0;
      write_m_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      wait_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      address_q  <= address_d;
      wr_reg_q   <= wr_reg_d;
      instr_q    <= instr_d;
      rd_data_q  <= rd_data_d;
      read_m_q   <= read_m_d;
      write_m_q  <= write_m_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef BUS_TIMEOUT_EN
      wait_cnt_q <= wait_cnt_d;
`endif
    end
  end

  // Next-state and next-output logic; done is a pulse so it defaults low.
  always_comb begin
    state_d    = state_q;
    address_d  = address_q;
    wr_reg_d   = wr_reg_q;
    instr_d    = instr_q;
    rd_data_d  = rd_data_q;
    read_m_d   = read_m_q;
    write_m_d  = write_m_q;
    done_d     = 1'b0;
    err_d      = err_q;
`ifdef BUS_TIMEOUT_EN
    wait_cnt_d = wait_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (wr_req || rd_req || fetch_req) begin
          address_d = req_addr;
          wr_reg_d  = wr_data;
`ifdef BUS_TIMEOUT_EN
          wait_cnt_d = '0;
`endif
          // Write wins over read, read over fetch; losers are dropped.
          if (wr_req) begin
            write_m_d = 1'b1;
            state_d   = WRITE;
          end else if (rd_req) begin
            read_m_d = 1'b1;
            state_d  = READ;
          end else begin
            read_m_d = 1'b1;
            state_d  = FETCH;
          end
        end
      end

      FETCH, READ: begin
        if (inputReady) begin
          if (state_q == FETCH) instr_d = data;
          else                  rd_data_d = data;
          read_m_d = 1'b0;
          done_d   = 1'b1;
          err_d    = 1'b0;
          state_d  = DONE;
        end
`ifdef BUS_TIMEOUT_EN
        else if (wait_cnt_q == TMO_LAST) begin
          read_m_d = 1'b0;
          done_d   = 1'b1;
          err_d    = 1'b1;
          state_d  = DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
`endif
      end

      WRITE: begin
        if (ackOutput) begin
          write_m_d = 1'b0;
          done_d    = 1'b1;
          err_d     = 1'b0;
          state_d   = DONE;
        end
`ifdef BUS_TIMEOUT_EN
        else if (wait_cnt_q == TMO_LAST) begin
          write_m_d = 1'b0;
          done_d    = 1'b1;
          err_d     = 1'b1;
          state_d   = DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
`endif
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d   = IDLE;
        read_m_d  = 1'b0;
        write_m_d = 1'b0;
      end
    endcase
  end

  // Bus is driven only while the state register says WRITE.
  assign data = (state_q == WRITE) ? wr_reg_q : {WORD_SIZE{1'bz}};

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign err         = err_q;
  assign instruction = instr_q;
  assign rd_data     = rd_data_q;
  assign readM       = read_m_q;
  assign writeM      = write_m_q;
  assign address     = address_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: vector table of single transactions plus
// hand sequences for reset abort and the wait-state limit.
module tb_mem_bus_ctrl;

  localparam int unsigned W   = 16;
  localparam int unsigned TMO = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          fetch_req, rd_req, wr_req;
  logic [W-1:0]  req_addr, wr_data;
  logic          busy, done, err, readM, writeM;
  logic [W-1:0]  instruction, rd_data, address;
  wire  [W-1:0]  data;
  logic          inputReady, ackOutput;
  logic          mem_drive;
  logic [W-1:0]  mem_val;

  int n_checks = 0;
  int n_fail   = 0;

  // Memory side of the shared bus.
  assign data = mem_drive ? mem_val : {W{1'bz}};

  always #5 clk = ~clk;

  mem_bus_ctrl #(.WORD_SIZE(W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .fetch_req(fetch_req), .rd_req(rd_req), .wr_req(wr_req),
    .req_addr(req_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err),
    .instruction(instruction), .rd_data(rd_data),
    .readM(readM), .writeM(writeM), .address(address), .data(data),
    .inputReady(inputReady), .ackOutput(ackOutput)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // kind: 0 fetch, 1 read, 2 write
  typedef struct {
    logic         f, r, w;
    logic [W-1:0] addr, wdata;
    int           waits;
    logic [W-1:0] mem;
    logic [1:0]   kind;
    logic         noise;
    logic [W-1:0] exp_instr, exp_rd;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vec_t v;
    int   bad;
    int   cnt;

    vecs[0] = '{1'b1,1'b0,1'b0, 16'h0010,16'h0000, 0, 16'h6A05, 2'd0, 1'b0, 16'h6A05,16'h0000};
    vecs[1] = '{1'b0,1'b0,1'b1, 16'h00F0,16'hBEEF, 3, 16'h0000, 2'd2, 1'b1, 16'h6A05,16'h0000};
    vecs[2] = '{1'b1,1'b1,1'b1, 16'h0100,16'h1111, 1, 16'h9999, 2'd2, 1'b0, 16'h6A05,16'h0000};
    vecs[3] = '{1'b1,1'b1,1'b0, 16'h0200,16'h2222, 2, 16'hC3C3, 2'd1, 1'b1, 16'h6A05,16'hC3C3};
    vecs[4] = '{1'b1,1'b0,1'b0, 16'hFFFF,16'h0000, 2, 16'h0F0F, 2'd0, 1'b0, 16'h0F0F,16'hC3C3};
    vecs[5] = '{1'b0,1'b1,1'b0, 16'h8000,16'h0000, 0, 16'hFFFF, 2'd1, 1'b0, 16'h0F0F,16'hFFFF};
    vecs[6] = '{1'b0,1'b0,1'b1, 16'h8000,16'h0000, 0, 16'h5555, 2'd2, 1'b1, 16'h0F0F,16'hFFFF};

    reset_n = 1'b0; fetch_req = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
    req_addr = '0; wr_data = '0; inputReady = 1'b0; ackOutput = 1'b0;
    mem_drive = 1'b0; mem_val = '0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_readM", 32'(readM), 32'd0);
    check("rst_writeM", 32'(writeM), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_address", 32'(address), 32'd0);
    check("rst_instruction", 32'(instruction), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    mem_drive = 1'b1; mem_val = 16'h1234; #1;
    check("rst_bus_free", 32'(data), 32'h1234);
    mem_drive = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);

    // Table of single transactions
    for (int i = 0; i < 7; i++) begin
      v = vecs[i];
      fetch_req = v.f; rd_req = v.r; wr_req = v.w;
      req_addr = v.addr; wr_data = v.wdata;
      @(negedge clk);
      fetch_req = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
      req_addr = 16'hA5A5; wr_data = 16'h5A5A;
      bad = 0;
      for (int c = 0; c <= v.waits; c++) begin
        if (v.noise) begin rd_req = 1'b1; fetch_req = 1'b1; end
        if (v.kind == 2'd2) begin
          if (writeM !== 1'b1 || readM !== 1'b0 || data !== v.wdata) bad++;
        end else begin
          if (readM !== 1'b1 || writeM !== 1'b0) bad++;
        end
        if (address !== v.addr || done !== 1'b0 || busy !== 1'b1) bad++;
        if (c == v.waits) begin
          if (v.kind == 2'd2) ackOutput = 1'b1;
          else begin inputReady = 1'b1; mem_drive = 1'b1; mem_val = v.mem; end
        end else if (v.kind == 2'd2) begin
          inputReady = 1'b1;
        end else begin
          ackOutput = 1'b1;
        end
        @(negedge clk);
        if (c != v.waits) begin inputReady = 1'b0; ackOutput = 1'b0; end
      end
      inputReady = 1'b0; ackOutput = 1'b0; mem_drive = 1'b0;
      rd_req = 1'b0; fetch_req = 1'b0;
      check($sformatf("v%0d_strobe_window", i), 32'(bad), 32'd0);
      check($sformatf("v%0d_done", i), 32'(done), 32'd1);
      check($sformatf("v%0d_err", i), 32'(err), 32'd0);
      check($sformatf("v%0d_strobes_low", i), 32'({readM, writeM}), 32'd0);
      check($sformatf("v%0d_instruction", i), 32'(instruction), 32'(v.exp_instr));
      check($sformatf("v%0d_rd_data", i), 32'(rd_data), 32'(v.exp_rd));
      mem_drive = 1'b1; mem_val = 16'h1234; #1;
      check($sformatf("v%0d_bus_free", i), 32'(data), 32'h1234);
      mem_drive = 1'b0;
      if (v.noise) fetch_req = 1'b1;
      @(negedge clk);
      fetch_req = 1'b0;
      check($sformatf("v%0d_done_pulse", i), 32'({done, busy}), 32'd0);
      @(negedge clk);
      check($sformatf("v%0d_idle_after", i), 32'({busy, readM, writeM}), 32'd0);
    end

    // Reset in the middle of a read
    rd_req = 1'b1; req_addr = 16'h0300;
    @(negedge clk);
    rd_req = 1'b0;
    check("rstmid_readM_up", 32'(readM), 32'd1);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("rstmid_readM", 32'(readM), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_done", 32'(done), 32'd0);
    check("rstmid_regs", 32'({rd_data, instruction}), 32'd0);
    check("rstmid_address", 32'(address), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rstmid_no_done", 32'({done, busy}), 32'd0);

    // Preload rd_data so an aborted read can be seen not to touch it
    rd_req = 1'b1; req_addr = 16'h0400;
    @(negedge clk);
    rd_req = 1'b0; inputReady = 1'b1; mem_drive = 1'b1; mem_val = 16'h4321;
    @(negedge clk);
    inputReady = 1'b0; mem_drive = 1'b0;
    check("pre_rd_data", 32'(rd_data), 32'h4321);
    @(negedge clk);

    // Memory never answers a read
    rd_req = 1'b1; req_addr = 16'h0500;
    @(negedge clk);
    rd_req = 1'b0;
`ifdef BUS_TIMEOUT_EN
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (readM) cnt++;
      if (done) break;
      @(negedge clk);
    end
    check("tmo_readM_cycles", 32'(cnt), 32'(TMO));
    check("tmo_done", 32'(done), 32'd1);
    check("tmo_err", 32'(err), 32'd1);
    check("tmo_rd_data_kept", 32'(rd_data), 32'h4321);
    @(negedge clk);
    check("tmo_idle", 32'({busy, done}), 32'd0);
`else
    bad = 0;
    cnt = 0;
    for (int c = 0; c < 300; c++) begin
      if (readM !== 1'b1 || done !== 1'b0) bad++;
      cnt++;
      @(negedge clk);
    end
    check("notmo_readM_held", 32'(bad), 32'd0);
    check("notmo_still_busy", 32'({busy, readM}), 32'd3);
    inputReady = 1'b1; mem_drive = 1'b1; mem_val = 16'h7777;
    @(negedge clk);
    inputReady = 1'b0; mem_drive = 1'b0;
    check("notmo_done", 32'(done), 32'd1);
    check("notmo_err", 32'(err), 32'd0);
    check("notmo_rd_data", 32'(rd_data), 32'h7777);
    @(negedge clk);
    check("notmo_idle", 32'({busy, done}), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
